dispatch_resend_ctrl: RTL and testbench

//   Parametrised go-back-N dispatch stage: scrambles each input beat with a per-beat key

---
 rtl/dispatch_pkg.sv | 24 ++
 rtl/dispatch_key_tbl.sv | 32 +++
 rtl/dispatch_resend_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_dispatch_resend_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dispatch_pkg.sv
// Shared types for the go-back-N dispatch stage: FSM states and window entries.
package dispatch_pkg;

    // Widest order ID the window entry can carry; instances must use ID_W <= ID_MAX_W.
    localparam int ID_MAX_W = 16;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    typedef struct packed {
        logic                vld;
        logic [ID_MAX_W-1:0] id;
    } win_entry_t;

    function automatic win_entry_t make_entry(input logic vld, input logic [ID_MAX_W-1:0] id);
        win_entry_t e;
        e.vld = vld;
        e.id  = id;
        return e;
    endfunction

endpackage

// File: rtl/dispatch_key_tbl.sv
// Scramble key register file: one synchronous write port, one asynchronous read port.
module dispatch_key_tbl #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [IDX_W-1:0]  raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int DEPTH = 1 << IDX_W;

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // A read of the index being written this cycle sees the old contents.
    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dispatch_resend_ctrl.sv
// Go-back-N dispatch stage: scrambles and forwards beats, tracks in-flight IDs and
// drives resend requests with timeout-based re-issue and a sticky error abort.
module dispatch_resend_ctrl
    import dispatch_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ID_W      = 4,
    parameter int KEY_IDX_W = 3,
    parameter int WIN_DEPTH = 8,
    parameter int HOLD_TMO  = 64,
    parameter int MAX_RETRY = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_vld,
    input  logic [DATA_W-1:0]    in_data,
    input  logic [KEY_IDX_W-1:0] in_key_idx,
    input  logic [ID_W-1:0]      in_id,
    input  logic                 key_we,
    input  logic [KEY_IDX_W-1:0] key_waddr,
    input  logic [DATA_W-1:0]    key_wdata,
    input  logic                 tail_i,
    output logic                 out_vld,
    output logic [DATA_W-1:0]    out_data,
    output logic [ID_W-1:0]      out_id,
    output logic                 resend_en,
    output logic [ID_W-1:0]      resend_id,
    output logic                 hold_o,
    output logic                 err_o
);

    localparam int TMO_W   = $clog2(HOLD_TMO);
    localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [TMO_W-1:0]   TMO_LAST  = TMO_W'(HOLD_TMO - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

    state_t              state_q, state_d;
    logic [ID_MAX_W-1:0] hold_id_q, hold_id_d;
    logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic [RETRY_W-1:0]  retry_cnt_q, retry_cnt_d;
    logic                err_q, err_d;
    logic                resend_en_q, resend_en_d;
    logic [ID_W-1:0]     resend_id_q, resend_id_d;
    logic                out_vld_q, out_vld_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic [ID_W-1:0]     out_id_q, out_id_d;
    win_entry_t          win_q [WIN_DEPTH];
    win_entry_t          win_d [WIN_DEPTH];

    logic [DATA_W-1:0]   key_rd;
    logic                id_match;
    logic                accept;
    logic                win_clr;
    logic                oldest_vld;
    logic [ID_MAX_W-1:0] oldest_id;

    dispatch_key_tbl #(
        .DATA_W (DATA_W),
        .IDX_W  (KEY_IDX_W)
    ) u_key_tbl (
        .clk     (clk),
        .rst     (rst),
        .we_i    (key_we),
        .waddr_i (key_waddr),
        .wdata_i (key_wdata),
        .raddr_i (in_key_idx),
        .rdata_o (key_rd)
    );

    assign id_match = (ID_MAX_W'(in_id) == hold_id_q);
    assign accept   = (state_q == IDLE) || id_match;

    // Oldest in-flight entry is the highest-numbered valid stage; later hits override.
    always_comb begin
        oldest_vld = 1'b0;
        oldest_id  = '0;
        for (int k = 0; k < WIN_DEPTH; k++) begin
            if (win_q[k].vld) begin
                oldest_vld = 1'b1;
                oldest_id  = win_q[k].id;
            end
        end
    end

    always_comb begin
        out_vld_d  = in_vld && accept;
        out_data_d = in_vld ? (in_data ^ key_rd) : out_data_q;
        out_id_d   = in_vld ? in_id : out_id_q;
    end

    always_comb begin
        state_d     = state_q;
        hold_id_d   = hold_id_q;
        tmo_cnt_d   = tmo_cnt_q;
        retry_cnt_d = retry_cnt_q;
        err_d       = err_q;
        resend_en_d = 1'b0;
        resend_id_d = resend_id_q;
        win_clr     = 1'b0;
        case (state_q)
            IDLE: begin
                if (tail_i && oldest_vld) begin
                    state_d     = HOLD;
                    hold_id_d   = oldest_id;
                    resend_en_d = 1'b1;
                    resend_id_d = oldest_id[ID_W-1:0];
                    tmo_cnt_d   = '0;
                    retry_cnt_d = '0;
                    win_clr     = 1'b1;
                end
            end
            HOLD: begin
                // A returning beat takes priority over a timeout in the same cycle.
                if (in_vld && id_match) begin
                    state_d     = IDLE;
                    tmo_cnt_d   = '0;
                    retry_cnt_d = '0;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    tmo_cnt_d = '0;
                    if (retry_cnt_q < RETRY_MAX) begin
                        resend_en_d = 1'b1;
                        resend_id_d = hold_id_q[ID_W-1:0];
                        retry_cnt_d = retry_cnt_q + 1'b1;
                    end else begin
                        err_d       = 1'b1;
                        state_d     = IDLE;
                        retry_cnt_d = '0;
                    end
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        win_d[0] = make_entry(in_vld && accept, ID_MAX_W'(in_id));
        for (int k = 1; k < WIN_DEPTH; k++) begin
            win_d[k] = win_q[k-1];
        end
        if (win_clr) begin
            for (int k = 0; k < WIN_DEPTH; k++) begin
                win_d[k] = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            hold_id_q   <= '0;
            tmo_cnt_q   <= '0;
            retry_cnt_q <= '0;
            err_q       <= 1'b0;
            resend_en_q <= 1'b0;
            resend_id_q <= '0;
            out_vld_q   <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
            for (int k = 0; k < WIN_DEPTH; k++) begin
                win_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            hold_id_q   <= hold_id_d;
            tmo_cnt_q   <= tmo_cnt_d;
            retry_cnt_q <= retry_cnt_d;
            err_q       <= err_d;
            resend_en_q <= resend_en_d;
            resend_id_q <= resend_id_d;
            out_vld_q   <= out_vld_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
            for (int k = 0; k < WIN_DEPTH; k++) begin
                win_q[k] <= win_d[k];
            end
        end
    end

    assign out_vld   = out_vld_q;
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;
    assign resend_en = resend_en_q;
    assign resend_id = resend_id_q;
    assign hold_o    = (state_q == HOLD);
    assign err_o     = err_q;

endmodule

// File: tb/tb_dispatch_resend_ctrl.sv
// Self-checking bench for dispatch_resend_ctrl: beat and resend scoreboards plus directed checks.
module tb_dispatch_resend_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_vld;
    logic [31:0] in_data;
    logic [2:0]  in_key_idx;
    logic [3:0]  in_id;
    logic        key_we;
    logic [2:0]  key_waddr;
    logic [31:0] key_wdata;
    logic        tail_i;
    logic        out_vld;
    logic [31:0] out_data;
    logic [3:0]  out_id;
    logic        resend_en;
    logic [3:0]  resend_id;
    logic        hold_o;
    logic        err_o;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          err_cyc = -1;
    logic        prev_rs = 1'b0;
    logic [35:0] exp_q[$];
    logic [3:0]  rs_q[$];
    int          pulse_cyc[$];
    logic [35:0] exp_e;
    logic [31:0] key_m [8];

    dispatch_resend_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .in_vld     (in_vld),
        .in_data    (in_data),
        .in_key_idx (in_key_idx),
        .in_id      (in_id),
        .key_we     (key_we),
        .key_waddr  (key_waddr),
        .key_wdata  (key_wdata),
        .tail_i     (tail_i),
        .out_vld    (out_vld),
        .out_data   (out_data),
        .out_id     (out_id),
        .resend_en  (resend_en),
        .resend_id  (resend_id),
        .hold_o     (hold_o),
        .err_o      (err_o)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Scoreboard / monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (!rst) begin
            if (out_vld) begin
                if (exp_q.size() == 0) begin
                    check_eq("beat_unexpected", 1, 0);
                end else begin
                    exp_e = exp_q.pop_front();
                    check_eq("beat", {out_id, out_data}, exp_e);
                end
            end
            if (resend_en) begin
                pulse_cyc.push_back(cyc);
                if (prev_rs) check_eq("resend_back_to_back", 1, 0);
                if (rs_q.size() == 0) check_eq("resend_unexpected", 1, 0);
                else check_eq("resend_id", resend_id, rs_q.pop_front());
            end
            if (err_o && err_cyc < 0) err_cyc = cyc;
            prev_rs = resend_en;
        end else begin
            prev_rs = 1'b0;
        end
    end

    // Driver tasks
    task automatic drive(input logic v, input logic [31:0] d, input logic [2:0] idx,
                         input logic [3:0] id, input logic tail, input logic fwd);
        in_vld     = v;
        in_data    = d;
        in_key_idx = idx;
        in_id      = id;
        tail_i     = tail;
        if (v && fwd) exp_q.push_back({id, d ^ key_m[idx]});
        @(posedge clk);
        #1;
        in_vld = 1'b0;
        tail_i = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic key_write(input logic [2:0] a, input logic [31:0] d);
        key_we    = 1'b1;
        key_waddr = a;
        key_wdata = d;
        @(posedge clk);
        #1;
        key_we    = 1'b0;
        key_m[a]  = d;
    endtask

    task automatic drain_check(input string tag);
        check_eq(tag, exp_q.size() + rs_q.size(), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        rs_q.delete();
        pulse_cyc.delete();
        err_cyc = -1;
        for (int i = 0; i < 8; i++) key_m[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        in_vld     = 1'b0;
        in_data    = '0;
        in_key_idx = '0;
        in_id      = '0;
        key_we     = 1'b0;
        key_waddr  = '0;
        key_wdata  = '0;
        tail_i     = 1'b0;
        for (int i = 0; i < 8; i++) key_m[i] = '0;
        #12;
        check_eq("reset_outputs", {out_vld, out_data, out_id, resend_en, resend_id, hold_o, err_o}, 0);
        do_reset();

        // Scrambling, same-cycle key write/read, random traffic in IDLE
        key_write(3'd2, 32'h0000_ffff);
        drive(1'b1, 32'h1234_5678, 3'd2, 4'd7, 1'b0, 1'b1);
        check_eq("t1_data", out_data, 32'h1234_a987);
        key_we = 1'b1; key_waddr = 3'd2; key_wdata = 32'hffff_0000;
        drive(1'b1, 32'hdead_beef, 3'd2, 4'd8, 1'b0, 1'b1);
        check_eq("t1_old_key", out_data, 32'hdead_4110);
        key_we = 1'b0; key_m[2] = 32'hffff_0000;
        drive(1'b1, 32'hdead_beef, 3'd2, 4'd9, 1'b0, 1'b1);
        check_eq("t1_new_key", out_data, 32'h2152_beef);
        for (int i = 0; i < 16; i++) begin
            if ($urandom_range(0, 2) == 0) key_write(3'($urandom_range(0, 7)), $urandom);
            drive(1'b1, $urandom, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 1'b0, 1'b1);
        end
        idle(2);
        drain_check("t1_drain");

        // Resend of oldest ID; tail during HOLD is ignored
        do_reset();
        for (int i = 1; i <= 5; i++) drive(1'b1, 32'(i * 17), 3'd0, 4'(i), 1'b0, 1'b1);
        rs_q.push_back(4'd1);
        drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
        check_eq("t2_resend_en", resend_en, 1);
        check_eq("t2_resend_id", resend_id, 1);
        check_eq("t2_hold", hold_o, 1);
        drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
        idle(2);
        check_eq("t2_hold_stays", hold_o, 1);
        drive(1'b1, 32'h55, 3'd0, 4'd2, 1'b0, 1'b0);
        drive(1'b1, 32'h66, 3'd0, 4'd1, 1'b0, 1'b1);
        check_eq("t2_hold_exit", hold_o, 0);
        idle(2);
        check_eq("t2_pulse_count", pulse_cyc.size(), 1);
        drain_check("t2_drain");

        // HOLD(3): non-matching beats dropped, window afterwards holds only 3
        do_reset();
        for (int i = 3; i <= 5; i++) drive(1'b1, 32'(i), 3'd0, 4'(i), 1'b0, 1'b1);
        rs_q.push_back(4'd3);
        drive(1'b1, 32'h600, 3'd0, 4'd6, 1'b1, 1'b1);
        check_eq("t3_tail_beat_fwd", out_vld, 1);
        check_eq("t3_hold_enter", hold_o, 1);
        drive(1'b1, 32'h400, 3'd0, 4'd4, 1'b0, 1'b0);
        check_eq("t3_drop4", out_vld, 0);
        drive(1'b1, 32'h500, 3'd0, 4'd5, 1'b0, 1'b0);
        check_eq("t3_drop5", out_vld, 0);
        drive(1'b1, 32'h300, 3'd0, 4'd3, 1'b0, 1'b1);
        check_eq("t3_fwd3", out_vld, 1);
        check_eq("t3_hold_fall", hold_o, 0);
        rs_q.push_back(4'd3);
        drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
        check_eq("t3_window_id", resend_id, 3);
        drive(1'b1, 32'h301, 3'd0, 4'd3, 1'b0, 1'b1);
        idle(2);
        drain_check("t3_drain");

        // Timeout re-issue and error abort
        do_reset();
        drive(1'b1, 32'h9, 3'd0, 4'd9, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) rs_q.push_back(4'd9);
        drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 300 && !err_o; i++) idle(1);
        idle(1);
        check_eq("t4_err", err_o, 1);
        check_eq("t4_hold_low", hold_o, 0);
        check_eq("t4_pulses", pulse_cyc.size(), 4);
        if (pulse_cyc.size() == 4) begin
            for (int k = 1; k < 4; k++) check_eq("t4_pulse_gap", pulse_cyc[k] - pulse_cyc[0], 64 * k);
            check_eq("t4_err_time", err_cyc - pulse_cyc[0], 256);
        end
        drive(1'b1, 32'hab, 3'd0, 4'd4, 1'b0, 1'b1);
        idle(1);
        check_eq("t4_err_sticky", err_o, 1);
        drain_check("t4_drain");

        // Matching beat at the timeout cycle wins
        do_reset();
        drive(1'b1, 32'h2, 3'd0, 4'd2, 1'b0, 1'b1);
        rs_q.push_back(4'd2);
        drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
        idle(63);
        drive(1'b1, 32'h22, 3'd0, 4'd2, 1'b0, 1'b1);
        check_eq("t4b_hold_exit", hold_o, 0);
        idle(70);
        check_eq("t4b_pulses", pulse_cyc.size(), 1);
        check_eq("t4b_no_err", err_o, 0);
        drain_check("t4b_drain");

        // Tail with empty window
        do_reset();
        drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
        drive(1'b1, 32'h1, 3'd0, 4'd1, 1'b1, 1'b1);
        idle(3);
        check_eq("t5_no_hold", hold_o, 0);
        check_eq("t5_no_pulse", pulse_cyc.size(), 0);
        drain_check("t5_drain");

        // Asynchronous reset in the middle of HOLD
        do_reset();
        key_write(3'd2, 32'h0f0f_0f0f);
        drive(1'b1, 32'hcafe_f00d, 3'd2, 4'd5, 1'b0, 1'b1);
        rs_q.push_back(4'd5);
        drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
        idle(10);
        drain_check("t6_pre_drain");
        rst = 1'b1;
        #2;
        check_eq("t6_async_reset", {out_vld, out_data, out_id, resend_en, resend_id, hold_o, err_o}, 0);
        do_reset();
        drive(1'b1, 32'h1357_9bdf, 3'd2, 4'd7, 1'b0, 1'b1);
        check_eq("t6_key_zero", out_data, 32'h1357_9bdf);
        check_eq("t6_hold_low", hold_o, 0);
        idle(5);
        check_eq("t6_no_pulse", pulse_cyc.size(), 0);
        drain_check("t6_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
